// File: rtl/axi_aw_w_arbiter.sv
// axi_aw_w_arbiter
// Shares one downstream AXI write port among NB_SLAVE requesters.
// The AW channel is arbitrated round-robin. Each accepted AW index is queued
// in a small route FIFO, so W bursts are forwarded in the same order as AW.
//
// Handshake rule for every channel: a transfer occurs in the cycle where
// valid and ready are both 1 at the rising clock edge. Once an AW request is
// offered downstream (aw_valid_o=1 while aw_ready_i=0), the selected index
// is locked until that transfer completes, so the offered payload never changes.
module axi_aw_w_arbiter #(
    parameter int NB_SLAVE     = 4,
    parameter int W_FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // upstream AW
    input  logic [NB_SLAVE-1:0]               aw_valid_i,
    output logic [NB_SLAVE-1:0]               aw_ready_o,
    // upstream W
    input  logic [NB_SLAVE-1:0]               w_valid_i,
    input  logic [NB_SLAVE-1:0]               w_last_i,
    output logic [NB_SLAVE-1:0]               w_ready_o,
    // downstream AW
    output logic                              aw_valid_o,
    input  logic                              aw_ready_i,
    output logic [$clog2(NB_SLAVE)-1:0]       aw_sel_o,
    // downstream W
    output logic                              w_valid_o,
    output logic                              w_last_o,
    input  logic                              w_ready_i,
    output logic [$clog2(NB_SLAVE)-1:0]       w_sel_o,
    // route FIFO occupancy
    output logic [$clog2(W_FIFO_DEPTH+1)-1:0] w_pending_o
);

    localparam int SEL_W = $clog2(NB_SLAVE);
    localparam int CNT_W = $clog2(W_FIFO_DEPTH + 1);
    localparam int PTR_W = (W_FIFO_DEPTH > 1) ? $clog2(W_FIFO_DEPTH) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_sel_q, lock_sel_d;

    logic [SEL_W-1:0] fifo_mem_q [W_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // ------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------
    logic             aw_any;
    logic [SEL_W-1:0] arb_idx;
    logic             arb_found;
    int unsigned      arb_cand;
    logic [SEL_W-1:0] aw_grant;
    logic             fifo_full;
    logic             fifo_empty;
    logic             aw_hs;
    logic             w_pop;
    logic [SEL_W-1:0] fifo_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(W_FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign aw_any     = |aw_valid_i;
    assign fifo_full  = (count_q == CNT_W'(W_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_ptr_q;
        arb_cand  = 0;
        for (int i = 0; i < NB_SLAVE; i++) begin
            arb_cand = (int'(rr_ptr_q) + i) % NB_SLAVE;
            if (!arb_found && aw_valid_i[SEL_W'(arb_cand)]) begin
                arb_found = 1'b1;
                arb_idx   = SEL_W'(arb_cand);
            end
        end
    end

    // A pending (offered but not accepted) request keeps its index.
    assign aw_grant   = lock_q ? lock_sel_q : arb_idx;
    assign aw_sel_o   = aw_grant;
    assign aw_valid_o = aw_any & ~fifo_full;
    assign aw_hs      = aw_valid_o & aw_ready_i;

    // Upstream AW ready goes only to the granted requester.
    always_comb begin
        aw_ready_o = '0;
        if (aw_any && aw_ready_i && !fifo_full) begin
            aw_ready_o[aw_grant] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // W routing from the FIFO head (registered, so no fall-through)
    // ------------------------------------------------------------------
    assign fifo_head   = fifo_mem_q[rd_ptr_q];
    assign w_sel_o     = fifo_empty ? '0 : fifo_head;
    assign w_valid_o   = ~fifo_empty & w_valid_i[fifo_head];
    assign w_last_o    = w_last_i[fifo_head];
    assign w_pop       = w_valid_o & w_ready_i & w_last_o;
    assign w_pending_o = count_q;

    // Upstream W ready goes only to the requester at the FIFO head.
    always_comb begin
        w_ready_o = '0;
        if (!fifo_empty && w_ready_i) begin
            w_ready_o[fifo_head] = 1'b1;
        end
    end

    // Next state for pointer and lock: move only on a handshake.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        if (aw_hs) begin
            lock_d   = 1'b0;
            rr_ptr_d = (aw_grant == SEL_W'(NB_SLAVE - 1)) ? '0 : aw_grant + SEL_W'(1);
        end else if (aw_valid_o) begin
            lock_d     = 1'b1;
            lock_sel_d = aw_grant;
        end
    end

    // Next state for FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (aw_hs) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({aw_hs, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Arbiter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    // Route FIFO registers; a reset discards every pending route.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < W_FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (aw_hs) begin
                fifo_mem_q[wr_ptr_q] <= aw_grant;
            end
        end
    end

endmodule

// File: tb/tb_axi_aw_w_arbiter.sv
// Self-checking bench for axi_aw_w_arbiter (NB_SLAVE=4, W_FIFO_DEPTH=4).
// Inputs change on the falling edge, outputs are checked 1 ns later, and the
// reference model advances on the rising edge.
module tb_axi_aw_w_arbiter;

    localparam int NB    = 4;
    localparam int DEPTH = 4;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NB-1:0] aw_valid_i, aw_ready_o, w_valid_i, w_last_i, w_ready_o;
    logic          aw_valid_o, aw_ready_i, w_valid_o, w_last_o, w_ready_i;
    logic [1:0]    aw_sel_o, w_sel_o;
    logic [2:0]    w_pending_o;

    axi_aw_w_arbiter #(.NB_SLAVE(NB), .W_FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .aw_valid_i  (aw_valid_i),
        .aw_ready_o  (aw_ready_o),
        .w_valid_i   (w_valid_i),
        .w_last_i    (w_last_i),
        .w_ready_o   (w_ready_o),
        .aw_valid_o  (aw_valid_o),
        .aw_ready_i  (aw_ready_i),
        .aw_sel_o    (aw_sel_o),
        .w_valid_o   (w_valid_o),
        .w_last_o    (w_last_o),
        .w_ready_i   (w_ready_i),
        .w_sel_o     (w_sel_o),
        .w_pending_o (w_pending_o)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: AW order kept in a queue of requester indices
    // ------------------------------------------------------------------
    logic [1:0] exp_q[$];
    int         rr_m;
    bit         lock_m;
    int         lock_idx_m;
    int         g_m;
    bit         any_m, full_m, hs_m, pop_m;
    logic [NB-1:0] aw_hold;

    task automatic model_clear();
        exp_q.delete();
        rr_m   = 0;
        lock_m = 0;
        lock_idx_m = 0;
    endtask

    // Evaluate expectations from the current inputs and compare all outputs.
    task automatic model_check();
        int h;
        any_m  = |aw_valid_i;
        full_m = (exp_q.size() == DEPTH);
        if (lock_m) begin
            g_m = lock_idx_m;
        end else begin
            g_m = rr_m;
            for (int k = NB - 1; k >= 0; k--) begin
                if (aw_valid_i[(rr_m + k) % NB]) g_m = (rr_m + k) % NB;
            end
        end
        hs_m  = any_m && !full_m && aw_ready_i;
        pop_m = 0;
        check("aw_valid_o", 32'(aw_valid_o), 32'(any_m && !full_m));
        check("aw_ready_o", 32'(aw_ready_o), hs_m ? (32'd1 << g_m) : 32'd0);
        if (any_m) check("aw_sel_o", 32'(aw_sel_o), 32'(g_m));
        check("w_pending_o", 32'(w_pending_o), 32'(exp_q.size()));
        if (exp_q.size() == 0) begin
            check("w_valid_o_empty", 32'(w_valid_o), 32'd0);
            check("w_ready_o_empty", 32'(w_ready_o), 32'd0);
        end else begin
            h = int'(exp_q[0]);
            pop_m = w_valid_i[h] && w_ready_i && w_last_i[h];
            check("w_sel_o", 32'(w_sel_o), 32'(h));
            check("w_valid_o", 32'(w_valid_o), 32'(w_valid_i[h]));
            check("w_last_o", 32'(w_last_o), 32'(w_last_i[h]));
            check("w_ready_o", 32'(w_ready_o), w_ready_i ? (32'd1 << h) : 32'd0);
        end
    endtask

    // Advance the model by one clock edge.
    task automatic model_update();
        if (pop_m) void'(exp_q.pop_front());
        if (hs_m) begin
            exp_q.push_back(2'(g_m));
            rr_m   = (g_m + 1) % NB;
            lock_m = 0;
        end else if (any_m && !full_m) begin
            lock_m     = 1;
            lock_idx_m = g_m;
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic apply(input logic [NB-1:0] awv, input logic awr,
                         input logic [NB-1:0] wv, input logic [NB-1:0] wl, input logic wr);
        @(negedge clk);
        aw_valid_i = awv;
        aw_ready_i = awr;
        w_valid_i  = wv;
        w_last_i   = wl;
        w_ready_i  = wr;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    // Asynchronous reset asserted between clock edges; W inputs are left as-is.
    task automatic do_reset();
        @(negedge clk);
        aw_valid_i = '0;
        aw_hold    = '0;
        rst_n      = 1'b0;
        #1;
        model_clear();
        check("rst_w_pending", 32'(w_pending_o), 32'd0);
        check("rst_w_valid", 32'(w_valid_o), 32'd0);
        check("rst_w_ready", 32'(w_ready_o), 32'd0);
        check("rst_aw_ready", 32'(aw_ready_o), 32'd0);
        check("rst_aw_valid", 32'(aw_valid_o), 32'd0);
        check("rst_aw_sel", 32'(aw_sel_o), 32'd0);
        check("rst_w_sel", 32'(w_sel_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) begin
            apply('0, 1'b0, '1, '1, 1'b1);
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n      = 1'b0;
        aw_valid_i = '0;
        aw_ready_i = 1'b0;
        w_valid_i  = '0;
        w_last_i   = '0;
        w_ready_i  = 1'b0;
        aw_hold    = '0;
        model_clear();

        // Round-robin with all requesters held and W drained.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            apply(4'hF, 1'b1, 4'hF, 4'hF, 1'b1);
            check("rr_sequence", 32'(aw_sel_o), 32'(k % 4));
            tick();
        end
        drain();

        // Lock: requester 2 waits, requester 0 arrives, 2 keeps the grant.
        do_reset();
        apply(4'b0100, 1'b0, '0, '0, 1'b0);
        check("lock_first", 32'(aw_sel_o), 32'd2);
        tick();
        for (int k = 0; k < 2; k++) begin
            apply(4'b0101, 1'b0, '0, '0, 1'b0);
            check("lock_hold", 32'(aw_sel_o), 32'd2);
            tick();
        end
        apply(4'b0101, 1'b1, '0, '0, 1'b0);
        check("lock_hs_sel", 32'(aw_sel_o), 32'd2);
        check("lock_hs_ready", 32'(aw_ready_o), 32'b0100);
        tick();
        apply(4'b0001, 1'b1, '0, '0, 1'b0);
        check("after_lock_sel", 32'(aw_sel_o), 32'd0);
        tick();
        drain();

        // FIFO full blocks AW; a pop does not bypass in the same cycle.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            apply(4'hF, 1'b1, '0, '0, 1'b0);
            tick();
        end
        apply(4'hF, 1'b1, '0, '0, 1'b0);
        check("full_pending", 32'(w_pending_o), 32'd4);
        check("full_aw_valid", 32'(aw_valid_o), 32'd0);
        check("full_aw_ready", 32'(aw_ready_o), 32'd0);
        tick();
        apply(4'hF, 1'b1, 4'b0001, 4'b0001, 1'b1);
        check("full_pop_no_bypass", 32'(aw_ready_o), 32'd0);
        tick();
        apply(4'hF, 1'b1, '0, '0, 1'b0);
        check("after_pop_pending", 32'(w_pending_o), 32'd3);
        check("after_pop_aw_valid", 32'(aw_valid_o), 32'd1);
        check("after_pop_aw_ready", 32'(aw_ready_o), 32'b0001);
        tick();
        drain();

        // AW order 1 then 3, 4-beat bursts each, no W fall-through.
        do_reset();
        apply(4'b0010, 1'b1, 4'b1010, '0, 1'b1);
        check("no_fallthrough", 32'(w_valid_o), 32'd0);
        tick();
        apply(4'b1000, 1'b1, 4'b1010, '0, 1'b1);
        check("w_next_cycle", 32'(w_valid_o), 32'd1);
        check("burst1_sel_b1", 32'(w_sel_o), 32'd1);
        tick();
        for (int b = 2; b <= 4; b++) begin
            apply('0, 1'b0, 4'b1010, (b == 4) ? 4'b0010 : 4'b0000, 1'b1);
            check("burst1_sel", 32'(w_sel_o), 32'd1);
            check("burst1_ready", 32'(w_ready_o), 32'b0010);
            tick();
        end
        for (int b = 1; b <= 4; b++) begin
            apply('0, 1'b0, 4'b1010, (b == 4) ? 4'b1000 : 4'b0000, 1'b1);
            check("burst3_sel", 32'(w_sel_o), 32'd3);
            check("burst3_ready", 32'(w_ready_o), 32'b1000);
            tick();
        end
        apply('0, 1'b0, '0, '0, 1'b0);
        check("bursts_done", 32'(w_pending_o), 32'd0);
        tick();

        // Reset in the middle of a burst discards the route and the pointer.
        do_reset();
        apply(4'b0100, 1'b1, '0, '0, 1'b0);
        tick();
        for (int b = 0; b < 2; b++) begin
            apply('0, 1'b0, 4'b0100, '0, 1'b1);
            tick();
        end
        do_reset();
        apply(4'hF, 1'b1, 4'b0100, '0, 1'b1);
        check("post_rst_sel", 32'(aw_sel_o), 32'd0);
        check("post_rst_w_valid", 32'(w_valid_o), 32'd0);
        tick();
        drain();

        // Randomized traffic; AW valid stays up until its handshake.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end
            for (int i = 0; i < NB; i++) begin
                if (!aw_hold[i] && $urandom_range(0, 9) < 3) aw_hold[i] = 1'b1;
            end
            apply(aw_hold, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 6));
            tick();
            if (hs_m) aw_hold[g_m] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
